// File: rtl/mem_matmul_sequencer.sv
// ---------------------------------------------------------------------------
// mem_matmul_sequencer
//
// Computes C = A x B for square N x N matrices of 32-bit unsigned words that
// live in a single-ported data memory. A, B and C are stored row-major at the
// word addresses BASE_A, BASE_B and BASE_C. For every C element the sequencer
// walks the inner index k, reading A[i][k] and then B[k][j]. It accumulates
// the products modulo 2^32 and finally writes the sum back to C[i][j].
//
// Ports
//   clk              : single clock, all state changes on the rising edge
//   rst_n            : asynchronous active-low reset
//   start            : request a new computation (sampled only in IDLE)
//   busy             : high while reading operands or writing a result
//   done             : one-cycle pulse after the last C element is written
//   mem_address      : data memory word address
//   mem_write_data   : data memory write value (the finished dot product)
//   mem_write_enable : data memory write strobe
//   mem_read_enable  : data memory read strobe
//   mem_read_data    : combinational read data, valid in the address cycle
// ---------------------------------------------------------------------------
module mem_matmul_sequencer #(
    parameter int N      = 3,
    parameter int BASE_A = 0,
    parameter int BASE_B = 9,
    parameter int BASE_C = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);

    // Index counters only need to reach N-1; keep at least one bit for N=1.
    localparam int            IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);
    localparam logic [31:0]   N32  = 32'(N);
    localparam logic [31:0]   BA32 = 32'(BASE_A);
    localparam logic [31:0]   BB32 = 32'(BASE_B);
    localparam logic [31:0]   BC32 = 32'(BASE_C);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [IW-1:0] k;
    logic [31:0]   acc;
    logic [31:0]   a_reg;

    logic          k_last;
    logic          last_element;
    logic [31:0]   addr_a;
    logic [31:0]   addr_b;
    logic [31:0]   addr_c;

    assign k_last       = (k == LAST);
    assign last_element = (i == LAST) && (j == LAST);

    // Row-major address decode, derived purely from the index registers so
    // the memory interface never sees a combinational path from start or
    // from the read data.
    assign addr_a = BA32 + (32'(i) * N32) + 32'(k);
    assign addr_b = BB32 + (32'(k) * N32) + 32'(j);
    assign addr_c = BC32 + (32'(i) * N32) + 32'(j);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: two read cycles per inner step, one write per
    // element, and a single DONE cycle before returning to IDLE. start is
    // only looked at in IDLE, so pulses during a run are ignored.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RD_A;
                end
            end
            RD_A: begin
                state_next = RD_B;
            end
            RD_B: begin
                state_next = k_last ? WR : RD_A;
            end
            WR: begin
                state_next = last_element ? DONE : RD_A;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: indices, the latched A operand and the running
    // dot-product accumulator. In RD_B k is left at N-1 on the final step
    // because the following WR clears it anyway. On the very last element j
    // wraps to 0 while i stays put; neither value is used again before the
    // next start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            a_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                RD_A: begin
                    a_reg <= mem_read_data;
                end
                RD_B: begin
                    acc <= acc + (a_reg * mem_read_data);
                    if (!k_last) begin
                        k <= k + ONE;
                    end
                end
                WR: begin
                    acc <= '0;
                    k   <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        if (i != LAST) begin
                            i <= i + ONE;
                        end
                    end else begin
                        j <= j + ONE;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the registered state. Everything stays 0 outside
    // the read/write states, so reads and writes can never overlap and an
    // asynchronous reset drops the whole memory interface immediately.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        unique case (state)
            RD_A: begin
                busy            = 1'b1;
                mem_address     = addr_a;
                mem_read_enable = 1'b1;
            end
            RD_B: begin
                busy            = 1'b1;
                mem_address     = addr_b;
                mem_read_enable = 1'b1;
            end
            WR: begin
                busy             = 1'b1;
                mem_address      = addr_c;
                mem_write_data   = acc;
                mem_write_enable = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
